// File: rtl/ring_pkg.sv
// Shared definitions for the ring/Johnson code decoder: code-mode selectors,
// lock-state encoding and the state-count helper.
package ring_pkg;

  localparam int CODE_RING    = 0;
  localparam int CODE_JOHNSON = 1;

  typedef logic [0:0] lock_state_t;
  localparam lock_state_t UNLOCKED = 1'b0;
  localparam lock_state_t LOCKED   = 1'b1;

  // Number of distinct positions the code walks through before repeating.
  function automatic int state_count(input int width, input int johnson);
    return (johnson != CODE_RING) ? 2 * width : width;
  endfunction

endpackage

// File: rtl/ring_code_classify.sv
// Combinational classifier: flags whether a code word is legal for the selected
// mode and converts it to its binary position in the sequence.
module ring_code_classify
  import ring_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int JOHNSON = 0,
  parameter int IDXW    = 4
) (
  input  logic [WIDTH-1:0] code,
  output logic             legal,
  output logic [IDXW-1:0]  index
);

  int               ones;
  logic [WIDTH-1:0] inv;
  logic             low_run;
  logic             high_run;
  logic [IDXW-1:0]  ring_idx;

  always_comb begin
    ones     = 0;
    ring_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      ones = ones + int'(code[i]);
      if (code[i]) ring_idx = IDXW'(i);
    end

    // A run of ones anchored at bit 0 clears completely when incremented.
    inv      = ~code;
    low_run  = ((code & (code + WIDTH'(1))) == '0);
    high_run = !code[0] && (code != '0) && ((inv & (inv + WIDTH'(1))) == '0);

    if (JOHNSON == CODE_JOHNSON) begin
      legal = low_run || high_run;
      index = low_run ? IDXW'(ones) : IDXW'(2 * WIDTH - ones);
    end else begin
      legal = (ones == 1);
      index = ring_idx;
    end
  end

endmodule

// File: rtl/ring_code_decoder.sv
// Receive-side decoder for ring or Johnson counter words: registered index,
// legality and ordering pulses, sequence lock and a lap counter.
module ring_code_decoder
  import ring_pkg::*;
#(
  parameter  int WIDTH    = 16,
  parameter  int JOHNSON  = 0,
  parameter  int LOCK_CNT = 4,
  parameter  int LAPW     = 8,
  localparam int N        = state_count(WIDTH, JOHNSON),
  localparam int IDXW     = $clog2(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] code,
  output logic [IDXW-1:0]  index,
  output logic             index_vld,
  output logic             illegal,
  output logic             seq_err,
  output logic             locked,
  output logic [LAPW-1:0]  lap_count
);

  localparam int              STEPW = $clog2(LOCK_CNT + 1);
  localparam logic [IDXW-1:0] LAST  = IDXW'(N - 1);

  logic              legal;
  logic [IDXW-1:0]   cls_idx;
  logic [IDXW-1:0]   nxt_idx;
  logic              in_order;
  logic              have_prev;
  logic [STEPW-1:0]  step_cnt;
  logic [STEPW-1:0]  step_inc;
  lock_state_t       state;

  ring_code_classify #(
    .WIDTH   (WIDTH),
    .JOHNSON (JOHNSON),
    .IDXW    (IDXW)
  ) u_classify (
    .code  (code),
    .legal (legal),
    .index (cls_idx)
  );

  assign nxt_idx  = (index == LAST) ? '0 : index + IDXW'(1);
  assign in_order = (cls_idx == nxt_idx);
  assign step_inc = (step_cnt == STEPW'(LOCK_CNT)) ? step_cnt : step_cnt + STEPW'(1);
  assign locked   = (state == LOCKED);

  always_ff @(posedge clk) begin
    if (reset) begin
      index     <= '0;
      index_vld <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      lap_count <= '0;
      have_prev <= 1'b0;
      step_cnt  <= '0;
      state     <= UNLOCKED;
    end else begin
      index_vld <= 1'b0;
      illegal   <= 1'b0;
      seq_err   <= 1'b0;
      if (in_valid) begin
        if (!legal) begin
          illegal   <= 1'b1;
          have_prev <= 1'b0;
          step_cnt  <= '0;
          state     <= UNLOCKED;
        end else begin
          // Any legal word becomes the new reference, even out of order.
          index     <= cls_idx;
          index_vld <= 1'b1;
          have_prev <= 1'b1;
          if (have_prev) begin
            if (in_order) begin
              step_cnt <= step_inc;
              if (step_inc == STEPW'(LOCK_CNT)) state <= LOCKED;
              if (state == LOCKED && index == LAST) lap_count <= lap_count + LAPW'(1);
            end else begin
              seq_err  <= 1'b1;
              step_cnt <= '0;
              state    <= UNLOCKED;
            end
          end
        end
      end
    end
  end

endmodule
